// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and width helper for the CDC handshake arbiter
// Purpose : handshake FSM state encoding and index-width helper.
// Ports   : none (package).
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    REL   = 2'd2,
    ABORT = 2'd3
  } cdc_hs_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cdc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_two_flop_synchronizer.sv
// rtl/cdc_two_flop_synchronizer.sv - two-flop synchroniser for asynchronous inputs
// Purpose : bring an asynchronous level into the clk_i domain (2-edge latency).
// Ports   : clk_i  - destination clock
//           rst_ni - asynchronous active-low reset
//           d_i    - asynchronous input
//           q_o    - synchronised output
module cdc_two_flop_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/cdc_handshake_tx_arbiter.sv
// rtl/cdc_handshake_tx_arbiter.sv - round-robin arbiter driving one 4-phase req/ack CDC channel
// Purpose : share a single 4-phase crossing between N_REQ source-domain requesters.
// Ports   : clk_i   - source clock
//           rst_ni  - asynchronous active-low reset
//           req_i   - per-requester level request, held until done_o/err_o
//           data_i  - flattened payloads, requester k at [k*WIDTH +: WIDTH]
//           done_o  - one-hot completion pulse for the owner
//           err_o   - one-hot timeout-abort pulse for the owner
//           busy_o  - FSM not idle
//           xreq_o  - registered request to the destination domain
//           xdata_o - registered payload, stable for the whole handshake
//           xack_i  - asynchronous acknowledge from the destination domain
module cdc_handshake_tx_arbiter
  import cdc_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       err_o,
  output logic                   busy_o,
  output logic                   xreq_o,
  output logic [WIDTH-1:0]       xdata_o,
  input  logic                   xack_i
);

  localparam int IW = cdc_idx_w(N_REQ);
  localparam int CW = cdc_idx_w(TIMEOUT_CYCLES + 1);

  cdc_hs_state_e    r_state, w_state_nxt;
  logic [IW-1:0]    r_owner, w_owner_nxt;
  logic [IW-1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_xreq, w_xreq_nxt;
  logic [WIDTH-1:0] r_xdata, w_xdata_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic [N_REQ-1:0] r_err, w_err_nxt;
  logic             w_ack_s;
  logic [N_REQ-1:0] w_req_masked;
  logic [IW-1:0]    w_pick;
  logic             w_timeout;

  cdc_two_flop_synchronizer #(.WIDTH(1)) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (xack_i),
    .q_o    (w_ack_s)
  );

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IW-1:0]    ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    return sum[IW-1:0];
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A requester that is being told done/err this cycle may still hold req_i;
  // it must not be regranted off that stale level.
  assign w_req_masked = req_i & ~(r_done | r_err);
  assign w_pick       = rr_pick(w_req_masked, r_ptr);
  // Phase counter starts at 0 on entry, so TIMEOUT_CYCLES-1 marks the last allowed cycle.
  assign w_timeout    = (TIMEOUT_CYCLES > 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_xreq_nxt  = r_xreq;
    w_xdata_nxt = r_xdata;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (|w_req_masked) begin
          w_owner_nxt = w_pick;
          w_xdata_nxt = data_i[int'(w_pick)*WIDTH +: WIDTH];
          w_xreq_nxt  = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_ack_s) begin
          w_xreq_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = REL;
        end else if (w_timeout) begin
          w_xreq_nxt         = 1'b0;
          w_err_nxt[r_owner] = 1'b1;
          w_ptr_nxt          = next_idx(r_owner);
          w_cnt_nxt          = '0;
          w_state_nxt        = ABORT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      REL: begin
        if (!w_ack_s) begin
          w_done_nxt[r_owner] = 1'b1;
          w_ptr_nxt           = next_idx(r_owner);
          w_cnt_nxt           = '0;
          w_state_nxt         = IDLE;
        end else if (w_timeout) begin
          w_err_nxt[r_owner] = 1'b1;
          w_ptr_nxt          = next_idx(r_owner);
          w_cnt_nxt          = '0;
          w_state_nxt        = ABORT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ABORT: begin
        // The destination may still be holding ack; never start a new
        // handshake until it has been seen low.
        w_cnt_nxt = '0;
        if (!w_ack_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_xreq  <= 1'b0;
      r_xdata <= '0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_xreq  <= w_xreq_nxt;
      r_xdata <= w_xdata_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign done_o  = r_done;
  assign err_o   = r_err;
  assign busy_o  = (r_state != IDLE);
  assign xreq_o  = r_xreq;
  assign xdata_o = r_xdata;

endmodule

// File: tb/tb_cdc_handshake_tx_arbiter.sv
// tb/tb_cdc_handshake_tx_arbiter.sv - scoreboard bench for cdc_handshake_tx_arbiter
module tb_cdc_handshake_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   done_o;
  logic [N-1:0]   err_o;
  logic           busy_o;
  logic           xreq_o;
  logic [W-1:0]   xdata_o;
  logic           xack_i = 1'b0;

  cdc_handshake_tx_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .data_i  (data_i),
    .done_o  (done_o),
    .err_o   (err_o),
    .busy_o  (busy_o),
    .xreq_o  (xreq_o),
    .xdata_o (xdata_o),
    .xack_i  (xack_i)
  );

  always #5 clk = ~clk;

  // ack modes: 0 normal, 1 never acks, 2 ack stuck high after rising
  typedef struct {
    int         owner;
    logic [7:0] data;
    int         mode;
  } exp_t;

  exp_t exp_q[$];
  int   mode_q[$];
  int   total = 0;
  int   bad   = 0;
  int   comp_seen = 0;
  int   m_ptr = 0;
  exp_t cur;
  bit   cur_valid = 0;

  int         b_cnt[N];
  logic [7:0] b_dat[N];
  int         b_mode;
  bit         b_force_drop;
  int         cnt_left[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Destination-side receiver model.
  initial begin
    int rs = 0;
    int md = 0;
    int dly = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        rs = 0;
        xack_i = 1'b0;
      end else begin
        case (rs)
          0: if (xreq_o) begin
               md  = (mode_q.size() > 0) ? mode_q.pop_front() : 0;
               dly = $urandom_range(0, 3);
               rs  = (md == 1) ? 4 : 1;
             end
          1: if (dly == 0) begin xack_i = 1'b1; rs = 2; end else dly--;
          2: if (!xreq_o) begin dly = $urandom_range(0, 3); rs = (md == 2) ? 5 : 3; end
          3: if (dly == 0) begin xack_i = 1'b0; rs = 0; end else dly--;
          4: if (!xreq_o) rs = 0;
          5: if (err_o != 0) begin dly = $urandom_range(1, 5); rs = 3; end
          default: rs = 0;
        endcase
      end
    end
  end

  // Monitor: match each grant and completion against the expected queue.
  initial begin
    bit prev_xreq = 0;
    bit stable_bad = 0;
    int hi_cnt = 0;
    int lo_cnt = 0;
    logic [N-1:0] exp_done, exp_err;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        cur_valid = 0;
        prev_xreq = 0;
      end else begin
        if (xreq_o && !prev_xreq && !cur_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 1, 0);
          end else begin
            cur = exp_q[0];
            cur_valid = 1;
            stable_bad = 0;
            hi_cnt = 0;
            lo_cnt = 0;
            chk("grant_data", xdata_o, cur.data);
            chk("grant_busy", busy_o, 1);
          end
        end
        if (done_o != 0 || err_o != 0) begin
          if (!cur_valid) begin
            chk("unexpected_completion", {done_o, err_o}, 0);
          end else begin
            exp_done = '0;
            exp_err  = '0;
            if (cur.mode == 0) exp_done[cur.owner] = 1'b1;
            else               exp_err[cur.owner]  = 1'b1;
            chk("done_onehot", done_o, exp_done);
            chk("err_onehot", err_o, exp_err);
            chk("xdata_stable", stable_bad | (xdata_o != cur.data), 0);
            if (cur.mode == 1) chk("req_phase_timeout", hi_cnt, TO);
            if (cur.mode == 2) chk("rel_phase_timeout", lo_cnt, TO);
            void'(exp_q.pop_front());
            cur_valid = 0;
            comp_seen++;
          end
        end else if (cur_valid) begin
          if (xdata_o != cur.data) stable_bad = 1;
          if (xreq_o) hi_cnt++;
          else        lo_cnt++;
        end
        prev_xreq = xreq_o;
      end
    end
  end

  // Reference model: service order is plain round-robin over outstanding
  // transfer counts, starting from the model pointer.
  task automatic run_batch();
    int c[N];
    int n_tot = 0;
    int p;
    int base;
    int cyc = 0;
    for (int k = 0; k < N; k++) begin
      c[k] = b_cnt[k];
      n_tot += c[k];
    end
    p = m_ptr;
    for (int n = 0; n < n_tot; n++) begin
      int w = -1;
      int md;
      int r;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && c[(p + i) % N] > 0) w = (p + i) % N;
      end
      r  = $urandom_range(0, 9);
      md = (b_mode >= 0) ? b_mode : ((r < 7) ? 0 : ((r < 9) ? 1 : 2));
      exp_q.push_back('{w, b_dat[w], md});
      mode_q.push_back(md);
      c[w]--;
      p = (w + 1) % N;
    end
    m_ptr = p;
    base  = comp_seen;
    for (int k = 0; k < N; k++) begin
      cnt_left[k] = b_cnt[k];
      data_i[k*W +: W] = b_dat[k];
      req_i[k] = (b_cnt[k] > 0);
    end
    @(negedge clk);
    chk("grant_latency", xreq_o, 1);
    while ((comp_seen - base) < n_tot && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (done_o[k] || err_o[k]) begin
          cnt_left[k]--;
          if (cnt_left[k] <= 0) begin
            req_i[k] = 1'b0;
            data_i[k*W +: W] = 8'($urandom);
          end
        end else if (cur_valid && cur.owner == k && cnt_left[k] == 1 && req_i[k] &&
                     !xreq_o && (b_force_drop || $urandom_range(0, 3) == 0)) begin
          req_i[k] = 1'b0;
          data_i[k*W +: W] = 8'($urandom);
        end
      end
    end
    if (cyc >= 3000) chk("batch_timeout", comp_seen - base, n_tot);
    repeat (12) @(negedge clk);
    chk("idle_after_batch", busy_o, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic set_batch(input int c0, c1, c2, c3, input int md, input bit fd);
    b_cnt[0] = c0; b_cnt[1] = c1; b_cnt[2] = c2; b_cnt[3] = c3;
    b_mode = md;
    b_force_drop = fd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_xreq", xreq_o, 0);
    chk("reset_xdata", xdata_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_busy", busy_o, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // all four held, requester 0 wants a second transfer
    for (int k = 0; k < N; k++) b_dat[k] = 8'(8'h10 + k);
    set_batch(2, 1, 1, 1, 0, 0);
    run_batch();

    // single request
    b_dat[0] = 8'hA5;
    set_batch(1, 0, 0, 0, 0, 0);
    run_batch();

    // no ack at all -> REQ timeout
    b_dat[2] = 8'h3C;
    set_batch(0, 0, 1, 0, 1, 0);
    run_batch();

    // ack stuck high -> REL timeout, then a normal transfer
    b_dat[0] = 8'h5A;
    set_batch(1, 0, 0, 0, 2, 0);
    run_batch();
    b_dat[2] = 8'h77;
    set_batch(0, 0, 1, 0, 0, 0);
    run_batch();

    // owner drops req_i during REL
    b_dat[1] = 8'hC3;
    set_batch(0, 1, 0, 0, 0, 1);
    run_batch();

    // async reset while in REQ; pointer is non-zero beforehand
    b_dat[2] = 8'h99;
    exp_q.push_back('{2, b_dat[2], 1});
    mode_q.push_back(1);
    data_i[2*W +: W] = b_dat[2];
    req_i = 4'b0100;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_reset_xreq", xreq_o, 0);
    chk("async_reset_busy", busy_o, 0);
    chk("async_reset_done_err", {done_o, err_o}, 0);
    req_i = '0;
    exp_q.delete();
    mode_q.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    b_dat[1] = 8'h21;
    b_dat[3] = 8'h43;
    set_batch(0, 1, 0, 1, 0, 0);
    run_batch();

    for (int it = 0; it < 40; it++) begin
      int s = 0;
      for (int k = 0; k < N; k++) begin
        b_cnt[k] = $urandom_range(0, 2);
        b_dat[k] = 8'($urandom);
        s += b_cnt[k];
      end
      if (s == 0) b_cnt[$urandom_range(0, N - 1)] = 1;
      b_mode = -1;
      b_force_drop = 0;
      run_batch();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
